// File: rtl/ntt_tw_pkg.sv
// -----------------------------------------------------------------------------
// ntt_tw_pkg
// Shared definitions for the twiddle ROM sequencer of the radix-16 NTT engine.
// Holds the state codes the TW_ROM instances decode, the FSM enum built on
// those codes, default datapath widths and the ROM enable polarity.
// -----------------------------------------------------------------------------
package ntt_tw_pkg;

    // Default widths used by the sequencer and the ROM bank
    localparam int DEF_P_WIDTH  = 64;
    localparam int DEF_SC_WIDTH = 3;
    localparam int DEF_S_WIDTH  = 4;

    // State codes as seen by the ROM on its state input
    localparam logic [DEF_S_WIDTH-1:0] CODE_IDLE  = 4'd0;
    localparam logic [DEF_S_WIDTH-1:0] CODE_LOAD  = 4'd1;
    localparam logic [DEF_S_WIDTH-1:0] CODE_GAP   = 4'd2;
    localparam logic [DEF_S_WIDTH-1:0] CODE_RUN_A = 4'd4;
    localparam logic [DEF_S_WIDTH-1:0] CODE_RUN_B = 4'd6;
    localparam logic [DEF_S_WIDTH-1:0] CODE_DONE  = 4'd8;

    // ROM enable is active-low
    localparam logic CEN_ON  = 1'b0;
    localparam logic CEN_OFF = 1'b1;

    // FSM states encoded directly with the ROM state codes, so the state
    // register can drive the ROM without a decode stage
    typedef enum logic [DEF_S_WIDTH-1:0] {
        TW_IDLE  = CODE_IDLE,
        TW_LOAD  = CODE_LOAD,
        TW_GAP   = CODE_GAP,
        TW_RUN_A = CODE_RUN_A,
        TW_RUN_B = CODE_RUN_B,
        TW_DONE  = CODE_DONE
    } tw_state_e;

endpackage

// File: rtl/tw_rd_counter.sv
// -----------------------------------------------------------------------------
// tw_rd_counter
// Read-address counter for one stage of ROM reads. Counts once per enabled
// cycle and wraps naturally at 2**CNT_W-1; wrap_o flags the enabled cycle on
// which the last read of the stage is being retired.
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   asynchronous reset, active-high
//   clr_i   in   synchronous clear to zero (has priority over en_i)
//   en_i    in   advance the count (deasserted while the datapath stalls)
//   cnt_o   out  current read index
//   wrap_o  out  count is at its maximum and advancing this cycle
// -----------------------------------------------------------------------------
module tw_rd_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && !clr_i && (cnt_q == '1);

endmodule

// File: rtl/tw_rom_sched.sv
// -----------------------------------------------------------------------------
// tw_rom_sched
// Sequencer for the 64-bit twiddle ROM bank of the radix-16 NTT engine.
// One start request runs a full transform: load LOAD_WORDS horizontal
// twiddles into the ROM stage-0 buffer, then for each of STAGE_NUM stages wait
// GAP_CYC idle cycles and issue CYC_PER_STAGE reads with CEN low. The state
// code toggles between RUN_A and RUN_B every 16 reads so the ROM can gate its
// internal read counters. All outputs are registered.
// Ports:
//   CLK                 in   clock, rising edge
//   rst                 in   asynchronous reset, active-high
//   start               in   single-cycle request (honoured only in IDLE)
//   stall               in   backpressure, freezes reads (honoured only in RUN)
//   hd_valid / hd_data  in   horizontal twiddle beat
//   hd_ready            out  beat accepted when hd_valid & hd_ready
//   horizontal_data_in  out  last accepted beat, to ROM
//   ROM0_w              out  stage-0 buffer write strobe, cycle after accept
//   stage_counter       out  current stage, to ROM
//   CEN                 out  ROM enable, active-low
//   state               out  state code, to ROM
//   busy                out  transform in progress
//   done                out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module tw_rom_sched
    import ntt_tw_pkg::*;
#(
    parameter int SC_WIDTH      = DEF_SC_WIDTH,
    parameter int P_WIDTH       = DEF_P_WIDTH,
    parameter int S_WIDTH       = DEF_S_WIDTH,
    parameter int STAGE_NUM     = 3,
    parameter int CYC_PER_STAGE = 1024,
    parameter int LOAD_WORDS    = 4,
    parameter int GAP_CYC       = 2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic                hd_valid,
    input  logic [P_WIDTH-1:0]  hd_data,
    output logic                hd_ready,
    output logic [P_WIDTH-1:0]  horizontal_data_in,
    output logic                ROM0_w,
    output logic [SC_WIDTH-1:0] stage_counter,
    output logic                CEN,
    output logic [S_WIDTH-1:0]  state,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W      = $clog2(CYC_PER_STAGE);
    localparam int BEAT_W     = $clog2(LOAD_WORDS + 1);
    localparam int GAP_W      = $clog2(GAP_CYC + 1);
    localparam int TOGGLE_BIT = 4;

    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(LOAD_WORDS - 1);
    localparam logic [GAP_W-1:0]    LAST_GAP   = GAP_W'(GAP_CYC - 1);
    localparam logic [SC_WIDTH-1:0] LAST_STAGE = SC_WIDTH'(STAGE_NUM - 1);
    localparam logic [CNT_W-1:0]    PHASE_MASK = CNT_W'(1 << TOGGLE_BIT);

    tw_state_e             state_q, state_d;
    logic                  hd_ready_q, hd_ready_d;
    logic [P_WIDTH-1:0]    hdata_q, hdata_d;
    logic                  rom0w_q, rom0w_d;
    logic [SC_WIDTH-1:0]   stage_q, stage_d;
    logic                  cen_q, cen_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [GAP_W-1:0]      gap_q, gap_d;

    logic                  cnt_clr;
    logic                  cnt_en;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      rd_next;
    logic                  rd_wrap;
    logic                  phase_next;

    tw_rd_counter #(
        .CNT_W (CNT_W)
    ) u_rd_counter (
        .clk_i  (CLK),
        .rst_i  (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (rd_cnt),
        .wrap_o (rd_wrap)
    );

    // The RUN_A/RUN_B choice must describe the read issued next cycle, so it
    // is taken from the incremented count rather than the current one.
    assign rd_next    = rd_cnt + 1'b1;
    assign phase_next = |(rd_next & PHASE_MASK);

    always_comb begin
        state_d    = state_q;
        hd_ready_d = hd_ready_q;
        hdata_d    = hdata_q;
        rom0w_d    = 1'b0;
        stage_d    = stage_q;
        cen_d      = CEN_OFF;
        busy_d     = busy_q;
        done_d     = 1'b0;
        beat_d     = beat_q;
        gap_d      = gap_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            TW_IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
                    state_d    = TW_LOAD;
                    busy_d     = 1'b1;
                    hd_ready_d = 1'b1;
                    beat_d     = '0;
                end
            end

            // hd_ready drops on the last accepted beat; the cycle after, with
            // that beat's ROM0_w strobe out, the FSM moves on to the gap.
            TW_LOAD: begin
                cnt_clr = 1'b1;
                if (hd_valid && hd_ready_q) begin
                    hdata_d = hd_data;
                    rom0w_d = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        hd_ready_d = 1'b0;
                    end
                end else if (!hd_ready_q) begin
                    state_d = TW_GAP;
                    gap_d   = '0;
                end
            end

            TW_GAP: begin
                cnt_clr = 1'b1;
                if (gap_q == LAST_GAP) begin
                    state_d = TW_RUN_A;
                    cen_d   = CEN_ON;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            // A stalled cycle freezes the count, code and stage; a wrap only
            // takes effect on a non-stalled cycle.
            TW_RUN_A, TW_RUN_B: begin
                if (!stall) begin
                    cnt_en = 1'b1;
                    if (rd_wrap) begin
                        if (stage_q < LAST_STAGE) begin
                            stage_d = stage_q + 1'b1;
                            state_d = TW_GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = TW_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            stage_d = '0;
                        end
                    end else begin
                        cen_d   = CEN_ON;
                        state_d = phase_next ? TW_RUN_B : TW_RUN_A;
                    end
                end
            end

            TW_DONE: begin
                state_d = TW_IDLE;
            end

            default: begin
                state_d = TW_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= TW_IDLE;
            hd_ready_q <= 1'b0;
            hdata_q    <= '0;
            rom0w_q    <= 1'b0;
            stage_q    <= '0;
            cen_q      <= CEN_OFF;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            hd_ready_q <= hd_ready_d;
            hdata_q    <= hdata_d;
            rom0w_q    <= rom0w_d;
            stage_q    <= stage_d;
            cen_q      <= cen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
        end
    end

    assign hd_ready           = hd_ready_q;
    assign horizontal_data_in = hdata_q;
    assign ROM0_w             = rom0w_q;
    assign stage_counter      = stage_q;
    assign CEN                = cen_q;
    assign state              = state_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_tw_rom_sched.sv
// -----------------------------------------------------------------------------
// tb_tw_rom_sched
// Scoreboard bench for tw_rom_sched with CYC_PER_STAGE=32. Each transform
// pushes its expected ROM writes, expected reads (stage, state code, and the
// cycle they must appear on when the schedule is deterministic) and an
// expected done into queues; a negedge monitor pops and compares them whenever
// the DUT shows ROM0_w, CEN low or done.
// -----------------------------------------------------------------------------
module tb_tw_rom_sched;

   localparam int STAGES = 3;
   localparam int CYC    = 32;
   localparam int WORDS  = 4;
   localparam int GAP    = 2;

   logic        CLK = 1'b0;
   logic        rst;
   logic        start;
   logic        stall;
   logic        hd_valid;
   logic [63:0] hd_data;
   logic        hd_ready;
   logic [63:0] horizontal_data_in;
   logic        ROM0_w;
   logic [2:0]  stage_counter;
   logic        CEN;
   logic [3:0]  state;
   logic        busy;
   logic        done;

   typedef struct {
      int stage;
      int code;
      int cyc;
   } readExp_t;

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } writeExp_t;

   readExp_t  readQ[$];
   writeExp_t writeQ[$];
   readExp_t  rItem;
   writeExp_t wItem;
   int        doneExpected = 0;
   int        doneCycExp   = -1;
   bit        doneSeen     = 1'b0;
   bit        monActive    = 1'b0;
   int        cycNow       = 0;
   int        compared     = 0;
   int        mismatched   = 0;

   tw_rom_sched #(
      .SC_WIDTH      (3),
      .P_WIDTH       (64),
      .S_WIDTH       (4),
      .STAGE_NUM     (STAGES),
      .CYC_PER_STAGE (CYC),
      .LOAD_WORDS    (WORDS),
      .GAP_CYC       (GAP)
   ) dut (
      .CLK                (CLK),
      .rst                (rst),
      .start              (start),
      .stall              (stall),
      .hd_valid           (hd_valid),
      .hd_data            (hd_data),
      .hd_ready           (hd_ready),
      .horizontal_data_in (horizontal_data_in),
      .ROM0_w             (ROM0_w),
      .stage_counter      (stage_counter),
      .CEN                (CEN),
      .state              (state),
      .busy               (busy),
      .done               (done)
   );

   // Free-running clock and a cycle index; cycle n is the period after edge n
   always #5 CLK = ~CLK;

   always @(posedge CLK) cycNow++;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycNow);
      end
   endtask

   // Monitor: consumes scoreboard entries whenever the DUT presents a write,
   // a read or a done pulse
   always @(negedge CLK) begin
      if (monActive && !rst) begin
         checkOutput("stageRange", stage_counter <= 3'(STAGES - 1), 1'b1);
         if (ROM0_w) begin
            checkOutput("writeQueued", writeQ.size() > 0, 1'b1);
            if (writeQ.size() > 0) begin
               wItem = writeQ.pop_front();
               checkOutput("writeData", horizontal_data_in, wItem.data);
               if (wItem.cyc >= 0) checkOutput("writeCycle", cycNow, wItem.cyc);
            end
         end
         if (CEN == 1'b0) begin
            checkOutput("readQueued", readQ.size() > 0, 1'b1);
            if (readQ.size() > 0) begin
               rItem = readQ.pop_front();
               checkOutput("readStage", stage_counter, rItem.stage);
               checkOutput("readCode", state, rItem.code);
               checkOutput("busyDuringRead", busy, 1'b1);
               if (rItem.cyc >= 0) checkOutput("readCycle", cycNow, rItem.cyc);
            end
         end
         if (done) begin
            checkOutput("doneExpected", doneExpected > 0, 1'b1);
            if (doneExpected > 0) begin
               doneExpected--;
               doneSeen = 1'b1;
               if (doneCycExp >= 0) checkOutput("doneCycle", cycNow, doneCycExp);
               checkOutput("readsLeftAtDone", readQ.size(), 0);
               checkOutput("writesLeftAtDone", writeQ.size(), 0);
               checkOutput("busyAtDone", busy, 1'b0);
               checkOutput("cenAtDone", CEN, 1'b1);
               checkOutput("stageAtDone", stage_counter, 0);
            end
         end
      end
   end

   // Mode 0: back-to-back beats, stray start pulses in LOAD, RUN and DONE
   // Mode 1: hd_valid toggling 1,0,1,0 with stall held high through LOAD/GAP
   // Mode 2: back-to-back beats, 5-cycle stall at read 10 of stage 1
   // Mode 3: random beats, random valid and random stall, ordering checks only
   task automatic applyStimulus(input int mode);
      int          s0;
      int          c;
      int          beatsSent;
      int          readBase;
      int          rc;
      logic [63:0] beats [WORDS];
      bit          v;

      for (int k = 0; k < WORDS; k++) begin
         if (mode == 3) beats[k] = {$urandom, $urandom};
         else           beats[k] = 64'h11 * 64'(k + 1);
      end

      @(negedge CLK);
      s0 = cycNow;
      // Start is high in cycle s0; LOAD begins in s0+1, and with an
      // uninterrupted load the last beat lands at s0+5, one more LOAD cycle,
      // two gap cycles, then read 0 at s0+8.
      readBase = (mode == 1) ? s0 + 11 : s0 + 8;
      for (int k = 0; k < WORDS; k++) begin
         writeQ.push_back('{data: beats[k],
                            cyc:  (mode == 3) ? -1 : ((mode == 1) ? s0 + 2 + 2 * k : s0 + 2 + k)});
      end
      for (int s = 0; s < STAGES; s++) begin
         for (int k = 0; k < CYC; k++) begin
            rc = readBase + s * (CYC + GAP) + k;
            if (mode == 2 && (s > 1 || (s == 1 && k > 10))) rc += 5;
            readQ.push_back('{stage: s,
                              code:  ((k / 16) % 2 == 0) ? 4 : 6,
                              cyc:   (mode == 3) ? -1 : rc});
         end
      end
      doneExpected++;
      doneCycExp = (mode == 3) ? -1
                 : readBase + STAGES * (CYC + GAP) - GAP + ((mode == 2) ? 5 : 0);
      doneSeen  = 1'b0;
      beatsSent = 0;
      start     = 1'b1;

      while (!doneSeen && cycNow < s0 + 2000) begin
         @(negedge CLK);
         c     = cycNow - s0;
         start = (mode == 0) && (c == 2 || c == 20 || c == 108);
         case (mode)
            1:       stall = (c <= 10);
            2:       stall = (c >= 52 && c <= 56);
            3:       stall = ($urandom_range(0, 3) == 0);
            default: stall = 1'b0;
         endcase
         v = 1'b0;
         if (beatsSent < WORDS) begin
            case (mode)
               1:       v = ((c - 1) % 2 == 0);
               3:       v = ($urandom_range(0, 1) == 1);
               default: v = 1'b1;
            endcase
            if (mode == 1) checkOutput("hdReadyInGaps", hd_ready, 1'b1);
         end
         hd_valid = v;
         hd_data  = v ? beats[beatsSent] : 64'h0;
         if (v && hd_ready) beatsSent++;
      end

      checkOutput("doneArrived", doneSeen, 1'b1);
      @(negedge CLK);
      start    = 1'b0;
      stall    = 1'b0;
      hd_valid = 1'b0;
      hd_data  = 64'h0;
      if (!doneSeen) begin
         readQ.delete();
         writeQ.delete();
         doneExpected = 0;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("idleBusy", busy, 1'b0);
         checkOutput("idleCode", state, 4'd0);
         checkOutput("idleCen", CEN, 1'b1);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_hdReady"}, hd_ready, 1'b0);
      checkOutput({tag, "_hData"}, horizontal_data_in, 64'h0);
      checkOutput({tag, "_rom0w"}, ROM0_w, 1'b0);
      checkOutput({tag, "_stage"}, stage_counter, 3'd0);
      checkOutput({tag, "_cen"}, CEN, 1'b1);
      checkOutput({tag, "_code"}, state, 4'd0);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_done"}, done, 1'b0);
   endtask

   // Asynchronous reset in the middle of stage 1; outputs must clear before
   // the next clock edge and the sequencer must come back idle
   task automatic resetTest();
      int s0;
      int c;
      int beatsSent;

      monActive = 1'b0;
      @(negedge CLK);
      s0        = cycNow;
      start     = 1'b1;
      beatsSent = 0;
      c         = 0;
      while (c < 60) begin
         @(negedge CLK);
         c        = cycNow - s0;
         start    = 1'b0;
         hd_valid = (beatsSent < WORDS);
         hd_data  = 64'hA5A5_0000_0000_0000 + 64'(beatsSent + 1);
         if (hd_valid && hd_ready) beatsSent++;
      end
      hd_valid = 1'b0;
      checkOutput("cenBeforeReset", CEN, 1'b0);
      checkOutput("stageBeforeReset", stage_counter, 3'd1);
      #2 rst = 1'b1;
      #1 checkResetValues("midRunReset");
      repeat (2) @(negedge CLK);
      rst = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("postResetCode", state, 4'd0);
      checkOutput("postResetCen", CEN, 1'b1);
      checkOutput("postResetBusy", busy, 1'b0);
      checkOutput("postResetReady", hd_ready, 1'b0);
      monActive = 1'b1;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      stall    = 1'b0;
      hd_valid = 1'b0;
      hd_data  = 64'h0;
      repeat (2) @(negedge CLK);
      checkResetValues("initReset");
      rst = 1'b0;
      @(negedge CLK);
      monActive = 1'b1;

      applyStimulus(0);
      applyStimulus(1);
      applyStimulus(2);
      applyStimulus(3);
      applyStimulus(3);
      resetTest();
      applyStimulus(3);
      applyStimulus(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Backstop against a sequencer that never settles
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected < 200000", cycNow);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
